// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver and JK register bank benches:
// driver FSM state encoding and the {j,k} excitation pair encodings.
package jk_pkg;

  // Driver FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Excitation pairs, packed as {j,k}
  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_RST  = 2'b01;
  localparam logic [1:0] EXC_SET  = 2'b10;
  localparam logic [1:0] EXC_TGL  = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// Single-bit JK excitation lookup: given the present q and the wanted next
// state t, produce the j/k pair that moves one JK flip-flop from q to t.
// TOGGLE_PREF picks how the don't-care half of the table is resolved.
module jk_excite_bit
  import jk_pkg::*;
#(
  parameter int TOGGLE_PREF = 0
) (
  input  logic q_i,
  input  logic t_i,
  output logic j_o,
  output logic k_o
);

  logic [1:0] pair_d;

  // Excitation table; equal q/t always holds so the bit never glitches
  always_comb begin
    pair_d = EXC_HOLD;
    unique case ({q_i, t_i})
      2'b01:   pair_d = (TOGGLE_PREF != 0) ? EXC_TGL : EXC_SET;
      2'b10:   pair_d = (TOGGLE_PREF != 0) ? EXC_TGL : EXC_RST;
      default: pair_d = EXC_HOLD;
    endcase
  end

  assign j_o = pair_d[1];
  assign k_o = pair_d[0];

endmodule

// File: rtl/jkff_excite_drv.sv
// Driver for an external bank of WIDTH JK flip-flops. Accepts a target word,
// drives one cycle of j/k excitation, reads q back and retries on mismatch
// up to MAX_RETRY extra times, then pulses done or err.
module jkff_excite_drv
  import jk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int TOGGLE_PREF = 0,
  parameter int MAX_RETRY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [3:0]       tries
);

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  state_e           state_q;
  logic [WIDTH-1:0] target_q;
  logic [3:0]       retry_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic             done_q;
  logic             err_q;
  logic [3:0]       tries_q;

  logic [WIDTH-1:0] tgt_sel_d;
  logic [WIDTH-1:0] exc_j_d;
  logic [WIDTH-1:0] exc_k_d;
  logic [3:0]       tries_d;

  // On acceptance the target register is not loaded yet, so excitation for
  // the first DRIVE is computed from the live request word; retries use the
  // captured copy.
  assign tgt_sel_d = (state_q == ST_IDLE) ? req_target : target_q;

  // Attempt count reported on completion; saturates when MAX_RETRY = 15
  // because 16 attempts do not fit the 4-bit field.
  assign tries_d = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_exc
      jk_excite_bit #(
        .TOGGLE_PREF(TOGGLE_PREF)
      ) u_exc (
        .q_i(q[gi]),
        .t_i(tgt_sel_d[gi]),
        .j_o(exc_j_d[gi]),
        .k_o(exc_k_d[gi])
      );
    end
  endgenerate

  // Control FSM with registered j/k, done, err and tries outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      retry_q  <= 4'd0;
      j_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tries_q  <= 4'd0;
    end else begin
      // Excitation and response pulses default off; only the edges entering
      // DRIVE or RESP raise them, which makes each a single-cycle value.
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            target_q <= req_target;
            retry_q  <= 4'd0;
            j_q      <= exc_j_d;
            k_q      <= exc_k_d;
            state_q  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Bank samples j/k at this edge; give it a hold cycle to read back
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (q == target_q) begin
            done_q  <= 1'b1;
            tries_q <= tries_d;
            state_q <= ST_RESP;
          end else if (retry_q < MAX_RETRY_C) begin
            retry_q <= retry_q + 4'd1;
            j_q     <= exc_j_d;
            k_q     <= exc_k_d;
            state_q <= ST_DRIVE;
          end else begin
            err_q   <= 1'b1;
            tries_q <= tries_d;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is held low while reset is asserted so nothing is offered early
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_jkff_excite_drv.sv
// Bench for jkff_excite_drv: two instances (set/reset and toggle encoding),
// each driving its own behavioural JK bank with an optional stuck-at-0 mask.
module tb_jkff_excite_drv;

  localparam int MAXR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_target = 4'd0;
  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] stuck = 4'd0;

  logic [3:0] bq0, bq1;
  logic [3:0] j0, k0, j1, k1, tries0, tries1;
  logic       rdy0, rdy1, done0, done1, err0, err1;
  logic       rv0, rv1;

  assign rv0 = req_valid & ~sel;
  assign rv1 = req_valid & sel;

  jkff_excite_drv #(.WIDTH(4), .TOGGLE_PREF(0), .MAX_RETRY(MAXR)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0),
    .req_target(req_target), .q(bq0), .j(j0), .k(k0),
    .done(done0), .err(err0), .tries(tries0)
  );

  jkff_excite_drv #(.WIDTH(4), .TOGGLE_PREF(1), .MAX_RETRY(MAXR)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1),
    .req_target(req_target), .q(bq1), .j(j1), .k(k1),
    .done(done1), .err(err1), .tries(tries1)
  );

  // Behavioural JK banks: characteristic equation, stuck bits forced to 0
  always @(posedge clk) begin
    if (load_en) begin
      bq0 <= load_val;
      bq1 <= load_val;
    end else begin
      bq0 <= ((j0 & ~bq0) | (~k0 & bq0)) & ~stuck;
      bq1 <= ((j1 & ~bq1) | (~k1 & bq1)) & ~stuck;
    end
  end

  logic [3:0] cur_j, cur_k, cur_tries, cur_q;
  logic       cur_ready, cur_done, cur_err;
  assign cur_j     = sel ? j1 : j0;
  assign cur_k     = sel ? k1 : k0;
  assign cur_tries = sel ? tries1 : tries0;
  assign cur_q     = sel ? bq1 : bq0;
  assign cur_ready = sel ? rdy1 : rdy0;
  assign cur_done  = sel ? done1 : done0;
  assign cur_err   = sel ? err1 : err0;

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference excitation from the table: only differing bits are excited;
  // set/reset mode drives toward the target, toggle mode uses j=k=1.
  function automatic logic [7:0] ref_exc(input logic [3:0] qv, input logic [3:0] tv,
                                         input logic pref);
    logic [3:0] diff;
    diff = qv ^ tv;
    if (pref) return {diff, diff};
    return {diff & tv, diff & ~tv};
  endfunction

  // Called at a falling edge; loads the bank and returns at the next falling edge
  task automatic preload(input logic [3:0] v);
    load_val = v;
    load_en  = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
    @(negedge clk);
  endtask

  // One request, checked cycle by cycle against the reference model.
  // Entered and left at a falling edge in an IDLE cycle.
  task automatic run(input string nm, input logic s, input logic do_load,
                     input logic [3:0] q0, input logic [3:0] tgt, input logic [3:0] stk,
                     input logic hold, input logic [3:0] next_tgt,
                     output logic [3:0] gj, output logic [3:0] gk,
                     output logic [3:0] gtries, output logic gdone);
    logic [3:0] qm, ej, ek;
    int         n;
    logic       ok;
    sel = s;
    if (do_load) begin
      stuck = stk;
      preload(q0 & ~stk);
    end
    qm = cur_q;
    gj = 4'd0;
    gk = 4'd0;
    chk({nm, ".ready_before"}, {3'd0, cur_ready}, 4'd1);
    req_target = tgt;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    if (hold) req_target = next_tgt;
    else req_valid = 1'b0;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < MAXR + 1) begin
      n++;
      {ej, ek} = ref_exc(qm, tgt, s);
      @(negedge clk);
      chk({nm, ".drive_j"}, cur_j, ej);
      chk({nm, ".drive_k"}, cur_k, ek);
      chk({nm, ".drive_ready"}, {3'd0, cur_ready}, 4'd0);
      chk({nm, ".drive_resp"}, {2'd0, cur_done, cur_err}, 4'd0);
      if (n == 1) begin
        gj = cur_j;
        gk = cur_k;
      end
      qm = tgt & ~stk;
      ok = (qm == tgt);
      @(negedge clk);
      chk({nm, ".check_jk"}, cur_j | cur_k, 4'd0);
      chk({nm, ".check_resp"}, {2'd0, cur_done, cur_err}, 4'd0);
    end
    @(negedge clk);
    chk({nm, ".resp_done"}, {3'd0, cur_done}, {3'd0, ok});
    chk({nm, ".resp_err"}, {3'd0, cur_err}, {3'd0, !ok});
    chk({nm, ".resp_tries"}, cur_tries, 4'(n));
    chk({nm, ".resp_ready"}, {3'd0, cur_ready}, 4'd0);
    gtries = cur_tries;
    gdone  = cur_done;
    @(negedge clk);
    chk({nm, ".idle_ready"}, {3'd0, cur_ready}, 4'd1);
    chk({nm, ".idle_resp"}, {2'd0, cur_done, cur_err}, 4'd0);
    $display("txn %s inst=%0d q0=%b tgt=%b stuck=%b j1=%b k1=%b tries=%0d done=%b",
             nm, s, q0, tgt, stk, gj, gk, gtries, gdone);
  endtask

  typedef struct {
    logic       s;
    logic [3:0] q0;
    logic [3:0] tgt;
    logic [3:0] stk;
    logic [3:0] ej;
    logic [3:0] ek;
    logic [3:0] etries;
    logic       edone;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0] gj, gk, gt;
    logic       gd;

    vecs[0] = '{1'b0, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'd1, 1'b1};
    vecs[1] = '{1'b1, 4'b1100, 4'b0110, 4'b0000, 4'b1010, 4'b1010, 4'd1, 1'b1};
    vecs[2] = '{1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'd1, 1'b1};
    vecs[3] = '{1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'd3, 1'b0};
    vecs[4] = '{1'b1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'd1, 1'b1};
    vecs[5] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'd1, 1'b1};
    vecs[6] = '{1'b1, 4'b0011, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'd1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    preload(4'b0000);
    chk("rst.jk0", j0 | k0, 4'd0);
    chk("rst.jk1", j1 | k1, 4'd0);
    chk("rst.resp", {done0, err0, done1, err1}, 4'd0);
    chk("rst.tries0", tries0, 4'd0);
    chk("rst.ready_low", {2'd0, rdy0, rdy1}, 4'd0);
    rst = 1'b0;
    #1 chk("rst.ready_high", {2'd0, rdy0, rdy1}, 4'b0011);
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run($sformatf("vec%0d", i), vecs[i].s, 1'b1, vecs[i].q0, vecs[i].tgt, vecs[i].stk,
          1'b0, 4'd0, gj, gk, gt, gd);
      chk($sformatf("vec%0d.j1", i), gj, vecs[i].ej);
      chk($sformatf("vec%0d.k1", i), gk, vecs[i].ek);
      chk($sformatf("vec%0d.tries", i), gt, vecs[i].etries);
      chk($sformatf("vec%0d.done", i), {3'd0, gd}, {3'd0, vecs[i].edone});
    end

    // Reset during DRIVE abandons the request
    sel   = 1'b0;
    stuck = 4'd0;
    preload(4'b0000);
    req_target = 4'b1111;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.drive_j", j0, 4'b1111);
    rst = 1'b1;
    #1;
    chk("rstmid.jk", j0 | k0, 4'd0);
    chk("rstmid.resp", {2'd0, done0, err0}, 4'd0);
    chk("rstmid.tries", tries0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid.resp_later", {2'd0, done0, err0}, 4'd0);
    rst = 1'b0;
    #1 chk("rstmid.ready", {3'd0, rdy0}, 4'd1);
    chk("rstmid.bank", bq0, 4'd0);
    $display("txn rstmid tgt=1111 abandoned tries=%0d", tries0);
    @(negedge clk);

    // Back-to-back with req_valid held high; target changes after capture
    run("b2b_a", 1'b0, 1'b1, 4'b0000, 4'b0011, 4'b0000, 1'b1, 4'b1100, gj, gk, gt, gd);
    run("b2b_b", 1'b0, 1'b0, 4'b0000, 4'b1100, 4'b0000, 1'b0, 4'd0, gj, gk, gt, gd);
    chk("b2b_b.j1", gj, 4'b1100);
    chk("b2b_b.k1", gk, 4'b0011);

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      logic       s;
      logic [3:0] q0, tgt, stk;
      s   = 1'($urandom_range(0, 1));
      q0  = 4'($urandom);
      tgt = 4'($urandom);
      stk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      run($sformatf("rnd%0d", i), s, 1'b1, q0, tgt, stk, 1'b0, 4'd0, gj, gk, gt, gd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
